// File: rtl/intc_gen_pkg.sv
// Shared register layouts, bus offsets and vector constants for the
// programmable interrupt controller.
package intc_gen_pkg;

  typedef struct packed {
    logic       nmil;
    logic [5:0] rsv_h;
    logic       nmie;
    logic [6:0] rsv_l;
    logic       vecmd;
  } ICRG_t;

  typedef struct packed {
    logic [3:0] pri;
    logic       edge_md;
    logic [3:0] rsv;
    logic [6:0] vec;
  } SRC_CFG_t;

  localparam ICRG_t    ICRG_INIT    = '0;
  localparam SRC_CFG_t SRC_CFG_INIT = '0;

  localparam logic [15:0] ICR_WMASK = 16'h0101;
  localparam logic [15:0] ICR_RMASK = 16'h8101;
  localparam logic [15:0] CFG_WMASK = 16'hF87F;
  localparam logic [15:0] CFG_RMASK = 16'hF87F;

  localparam logic [7:0] ICR_OFS  = 8'h00;
  localparam logic [7:0] PEND_OFS = 8'h04;
  localparam logic [7:0] CFG_OFS  = 8'h20;

  localparam logic [5:0] ICR_WORD  = ICR_OFS[7:2];
  localparam logic [5:0] PEND_WORD = PEND_OFS[7:2];
  localparam logic [5:0] CFG_WORD  = CFG_OFS[7:2];

  localparam logic [4:0] IRL_VEC_BASE = 5'b01000;
  localparam logic [7:0] NMI_VEC      = 8'd11;
  localparam logic [3:0] NMI_LVL      = 4'd15;

  // Byte-lane merge of a halfword write; be[1] covers the upper byte.
  function automatic logic [15:0] hw_merge(input logic [15:0] old_val,
                                           input logic [15:0] din,
                                           input logic [1:0]  be,
                                           input logic [15:0] wmask);
    logic [15:0] m;
    m = {{8{be[1]}}, {8{be[0]}}} & wmask;
    return (old_val & ~m) | (din & m);
  endfunction

endpackage

// File: rtl/intc_gen_prio_arb.sv
// Combinational max-priority search over the on-chip sources; equal
// priorities resolve to the lowest index.
module intc_prio_arb #(
  parameter int NUM_SRC = 16,
  parameter int IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic [NUM_SRC-1:0]      req,
  input  logic [NUM_SRC-1:0][3:0] pri,
  output logic                    valid,
  output logic [IDX_W-1:0]        idx,
  output logic [3:0]              lvl
);

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    lvl   = '0;
    // Strictly-greater replacement keeps the earliest index on ties.
    for (int i = 0; i < NUM_SRC; i++) begin
      if (req[i] && (!valid || (pri[i] > lvl))) begin
        valid = 1'b1;
        idx   = IDX_W'(i);
        lvl   = pri[i];
      end
    end
  end

endmodule

// File: rtl/intc_gen.sv
// Register-programmable interrupt controller: NMI, filtered IRL and NUM_SRC
// on-chip sources arbitrated into one registered CPU request.
module intc_gen
  import intc_gen_pkg::*;
#(
  parameter int          NUM_SRC   = 16,
  parameter int          IRL_FILT  = 5,
  parameter logic [31:0] BASE_ADDR = 32'hFFFFFD00
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               CE_R,
  input  logic               CE_F,
  input  logic               RES_N,
  input  logic               NMI_N,
  input  logic [3:0]         IRL_N,
  input  logic [31:0]        IBUS_A,
  input  logic [31:0]        IBUS_DI,
  output logic [31:0]        IBUS_DO,
  input  logic [3:0]         IBUS_BA,
  input  logic               IBUS_WE,
  input  logic               IBUS_REQ,
  output logic               IBUS_BUSY,
  output logic               IBUS_ACT,
  input  logic [NUM_SRC-1:0] SRC_IRQ,
  input  logic [3:0]         CPU_MASK,
  input  logic               INT_ACK,
  output logic               INT_REQ,
  output logic [3:0]         INT_LVL,
  output logic [7:0]         INT_VEC,
  output logic               INT_NMI
);

  localparam int IDX_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CFG_WORDS = (NUM_SRC + 1) / 2;
  localparam int CNT_W     = $clog2(IRL_FILT + 1);

  // Bus decode
  logic       in_block, hit_icr, hit_pend, hit_cfg;
  logic [5:0] word;
  logic       wr_en, wr_icr, wr_pend, rd_en;
  logic       unused_ok;

  assign in_block  = (IBUS_A[31:8] == BASE_ADDR[31:8]);
  assign word      = IBUS_A[7:2];
  assign hit_icr   = in_block && (word == ICR_WORD);
  assign hit_pend  = in_block && (word == PEND_WORD);
  assign hit_cfg   = in_block && (word >= CFG_WORD) && (word < (CFG_WORD + 6'(CFG_WORDS)));
  assign IBUS_ACT  = hit_icr || hit_pend || hit_cfg;
  assign IBUS_BUSY = 1'b0;
  assign wr_en     = IBUS_REQ && IBUS_WE;
  assign wr_icr    = wr_en && hit_icr;
  assign wr_pend   = wr_en && hit_pend;
  // Any in-block read captures, so unmapped holes return zero.
  assign rd_en     = IBUS_REQ && !IBUS_WE && in_block;
  assign unused_ok = ^IBUS_A[1:0];

  // State
  ICRG_t              icr_reg;
  logic [NUM_SRC-1:0] pend_reg, src_prev_reg;
  logic               nmi_prev_reg, nmi_req_reg;
  logic [3:0]         irl_prev_reg, irl_lvl_reg;
  logic [CNT_W-1:0]   irl_cnt_reg;
  logic               irl_req_reg;
  logic               int_req_reg, int_nmi_reg, win_irl_reg, win_src_reg;
  logic [3:0]         int_lvl_reg;
  logic [7:0]         int_vec_reg;
  logic [IDX_W-1:0]   win_idx_reg;
  logic [31:0]        ibus_do_reg;

  // Per-source configuration
  logic [NUM_SRC-1:0][3:0]     pri_all;
  logic [NUM_SRC-1:0][6:0]     vec_all;
  logic [NUM_SRC-1:0]          edge_all, w1c, req_q;
  logic [2*CFG_WORDS-1:0][15:0] cfg_rd;
  logic [NUM_SRC-1:0]          pend_view, pend_arb, pend_next, clr, ack_vec;

  logic ack;
  assign ack = INT_ACK && int_req_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2 * CFG_WORDS; gi++) begin : g_cfg
      if (gi < NUM_SRC) begin : g_src
        SRC_CFG_t    cfg_reg;
        logic        sel;
        logic [15:0] din;
        logic [1:0]  be;

        assign sel = wr_en && hit_cfg && (word == (CFG_WORD + 6'(gi / 2)));
        // Even index sits at the lower byte offset, i.e. the upper data lanes.
        assign din = (gi % 2 == 1) ? IBUS_DI[15:0] : IBUS_DI[31:16];
        assign be  = (gi % 2 == 1) ? IBUS_BA[1:0]  : IBUS_BA[3:2];

        always_ff @(posedge CLK or negedge RST_N) begin
          if (!RST_N) begin
            cfg_reg <= SRC_CFG_INIT;
          end else if (CE_R) begin
            if (!RES_N)
              cfg_reg <= SRC_CFG_INIT;
            else if (sel)
              cfg_reg <= SRC_CFG_t'(hw_merge(cfg_reg, din, be, CFG_WMASK));
          end
        end

        assign pri_all[gi]  = cfg_reg.pri;
        assign vec_all[gi]  = cfg_reg.vec;
        assign edge_all[gi] = cfg_reg.edge_md;
        assign cfg_rd[gi]   = cfg_reg & CFG_RMASK;
        assign w1c[gi]      = wr_pend && IBUS_DI[gi] && IBUS_BA[gi / 8];
        assign req_q[gi]    = pend_arb[gi] && (pri_all[gi] > CPU_MASK);
      end else begin : g_pad
        assign cfg_rd[gi] = '0;
      end
    end
  endgenerate

  // Pending: edge bits latch rises, level bits follow the pin.
  always_comb begin
    ack_vec = '0;
    if (ack && win_src_reg)
      ack_vec[win_idx_reg] = 1'b1;
  end

  assign pend_view = (pend_reg & edge_all) | (SRC_IRQ & ~edge_all);
  assign clr       = (ack_vec | w1c) & edge_all;
  assign pend_next = ((pend_reg & ~clr) | (SRC_IRQ & ~src_prev_reg)) & edge_all;
  // Arbitrate on the post-clear view so an acked source is not re-presented.
  assign pend_arb  = pend_view & ~clr;

  // NMI
  logic nmi_edge, nmi_clr, nmi_req_next, nmi_arb;
  assign nmi_edge     = icr_reg.nmie ? (!nmi_prev_reg && NMI_N) : (nmi_prev_reg && !NMI_N);
  assign nmi_clr      = ack && int_nmi_reg;
  assign nmi_req_next = nmi_req_reg ? !nmi_clr : nmi_edge;
  assign nmi_arb      = nmi_req_reg && !nmi_clr;

  // IRL filter
  logic [3:0]       irl_in, irl_lvl_next;
  logic [CNT_W-1:0] irl_cnt_next;
  logic             irl_accept, irl_clr, irl_req_next, irl_arb;

  assign irl_in = ~IRL_N;

  always_comb begin
    if (irl_in != irl_prev_reg)
      irl_cnt_next = CNT_W'(1);
    else if (irl_cnt_reg == CNT_W'(IRL_FILT))
      irl_cnt_next = irl_cnt_reg;
    else
      irl_cnt_next = irl_cnt_reg + 1'b1;
  end

  assign irl_accept   = (irl_cnt_next == CNT_W'(IRL_FILT)) && (irl_in != 4'd0) && !irl_req_reg;
  assign irl_clr      = ack && win_irl_reg;
  assign irl_req_next = irl_accept || (irl_req_reg && !irl_clr);
  assign irl_lvl_next = irl_accept ? irl_in : irl_lvl_reg;
  assign irl_arb      = irl_req_reg && !irl_clr && (irl_lvl_reg > CPU_MASK);

  // Arbitration
  logic             arb_valid;
  logic [IDX_W-1:0] arb_idx;
  logic [3:0]       arb_lvl;

  intc_prio_arb #(
    .NUM_SRC(NUM_SRC),
    .IDX_W  (IDX_W)
  ) u_arb (
    .req  (req_q),
    .pri  (pri_all),
    .valid(arb_valid),
    .idx  (arb_idx),
    .lvl  (arb_lvl)
  );

  logic             int_req_next, int_nmi_next, win_irl_next, win_src_next;
  logic [3:0]       int_lvl_next;
  logic [7:0]       int_vec_next;
  logic [IDX_W-1:0] win_idx_next;

  always_comb begin
    int_req_next = 1'b0;
    int_nmi_next = 1'b0;
    int_lvl_next = '0;
    int_vec_next = '0;
    win_irl_next = 1'b0;
    win_src_next = 1'b0;
    win_idx_next = '0;
    if (nmi_arb) begin
      int_req_next = 1'b1;
      int_nmi_next = 1'b1;
      int_lvl_next = NMI_LVL;
      int_vec_next = NMI_VEC;
    end else if (irl_arb) begin
      int_req_next = 1'b1;
      int_lvl_next = irl_lvl_reg;
      int_vec_next = {IRL_VEC_BASE, irl_lvl_reg[3:1]};
      win_irl_next = 1'b1;
    end else if (arb_valid) begin
      int_req_next = 1'b1;
      int_lvl_next = arb_lvl;
      int_vec_next = {1'b0, vec_all[arb_idx]};
      win_src_next = 1'b1;
      win_idx_next = arb_idx;
    end
  end

  // State registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      icr_reg      <= ICRG_INIT;
      pend_reg     <= '0;
      src_prev_reg <= '0;
      nmi_prev_reg <= 1'b1;
      nmi_req_reg  <= 1'b0;
      irl_prev_reg <= '0;
      irl_cnt_reg  <= '0;
      irl_req_reg  <= 1'b0;
      irl_lvl_reg  <= '0;
      int_req_reg  <= 1'b0;
      int_nmi_reg  <= 1'b0;
      int_lvl_reg  <= '0;
      int_vec_reg  <= '0;
      win_irl_reg  <= 1'b0;
      win_src_reg  <= 1'b0;
      win_idx_reg  <= '0;
    end else if (CE_R) begin
      if (!RES_N) begin
        icr_reg      <= ICRG_INIT;
        icr_reg.nmil <= NMI_N;
        pend_reg     <= '0;
        src_prev_reg <= '0;
        nmi_prev_reg <= NMI_N;
        nmi_req_reg  <= 1'b0;
        irl_prev_reg <= '0;
        irl_cnt_reg  <= '0;
        irl_req_reg  <= 1'b0;
        irl_lvl_reg  <= '0;
        int_req_reg  <= 1'b0;
        int_nmi_reg  <= 1'b0;
        int_lvl_reg  <= '0;
        int_vec_reg  <= '0;
        win_irl_reg  <= 1'b0;
        win_src_reg  <= 1'b0;
        win_idx_reg  <= '0;
      end else begin
        if (wr_icr)
          icr_reg <= ICRG_t'(hw_merge(icr_reg, IBUS_DI[31:16], IBUS_BA[3:2], ICR_WMASK));
        pend_reg     <= pend_next;
        src_prev_reg <= SRC_IRQ;
        nmi_prev_reg <= NMI_N;
        nmi_req_reg  <= nmi_req_next;
        irl_prev_reg <= irl_in;
        irl_cnt_reg  <= irl_cnt_next;
        irl_req_reg  <= irl_req_next;
        irl_lvl_reg  <= irl_lvl_next;
        int_req_reg  <= int_req_next;
        int_nmi_reg  <= int_nmi_next;
        int_lvl_reg  <= int_lvl_next;
        int_vec_reg  <= int_vec_next;
        win_irl_reg  <= win_irl_next;
        win_src_reg  <= win_src_next;
        win_idx_reg  <= win_idx_next;
      end
    end
  end

  // Read data
  logic [31:0] pend32, rd_data;

  always_comb begin
    pend32 = '0;
    pend32[NUM_SRC-1:0] = pend_view;
  end

  always_comb begin
    rd_data = '0;
    if (hit_icr) begin
      rd_data[31:16] = icr_reg & ICR_RMASK;
    end else if (hit_pend) begin
      rd_data = pend32;
    end else begin
      for (int j = 0; j < CFG_WORDS; j++) begin
        if (hit_cfg && (word == (CFG_WORD + 6'(j))))
          rd_data = {cfg_rd[2*j], cfg_rd[2*j+1]};
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      ibus_do_reg <= '0;
    else if (CE_R && !RES_N)
      ibus_do_reg <= '0;
    else if (CE_F && rd_en)
      ibus_do_reg <= rd_data;
  end

  assign IBUS_DO = ibus_do_reg;
  assign INT_REQ = int_req_reg;
  assign INT_LVL = int_lvl_reg;
  assign INT_VEC = int_vec_reg;
  assign INT_NMI = int_nmi_reg;

endmodule

// File: tb/tb_intc_gen.sv
// Directed bench for intc_gen: level/edge sources, IRL filter, NMI, register
// masking and soft reset, each checked against hand-computed values.
module tb_intc_gen;

  localparam int          NUM_SRC = 16;
  localparam logic [31:0] BASE    = 32'hFFFFFD00;

  logic               CLK, RST_N, CE_R, CE_F, RES_N, NMI_N;
  logic [3:0]         IRL_N, IBUS_BA, CPU_MASK;
  logic [31:0]        IBUS_A, IBUS_DI, IBUS_DO;
  logic               IBUS_WE, IBUS_REQ, IBUS_BUSY, IBUS_ACT;
  logic [NUM_SRC-1:0] SRC_IRQ;
  logic               INT_ACK, INT_REQ, INT_NMI;
  logic [3:0]         INT_LVL;
  logic [7:0]         INT_VEC;

  int checks = 0;
  int errors = 0;
  logic [31:0] rd;

  intc_gen #(.NUM_SRC(NUM_SRC), .IRL_FILT(5), .BASE_ADDR(BASE)) dut (
    .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R), .CE_F(CE_F), .RES_N(RES_N),
    .NMI_N(NMI_N), .IRL_N(IRL_N), .IBUS_A(IBUS_A), .IBUS_DI(IBUS_DI),
    .IBUS_DO(IBUS_DO), .IBUS_BA(IBUS_BA), .IBUS_WE(IBUS_WE), .IBUS_REQ(IBUS_REQ),
    .IBUS_BUSY(IBUS_BUSY), .IBUS_ACT(IBUS_ACT), .SRC_IRQ(SRC_IRQ),
    .CPU_MASK(CPU_MASK), .INT_ACK(INT_ACK), .INT_REQ(INT_REQ),
    .INT_LVL(INT_LVL), .INT_VEC(INT_VEC), .INT_NMI(INT_NMI)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %-14s got=%08h exp=%08h", tag, act, exp);
    end else begin
      $display("ok   %-14s got=%08h", tag, act);
    end
  endtask

  function automatic logic [31:0] pk(input logic r, input logic n,
                                     input logic [3:0] l, input logic [7:0] v);
    return {18'h0, r, n, l, v};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic bus_wr(input logic [7:0] ofs, input logic [31:0] d, input logic [3:0] be);
    IBUS_A = BASE + {24'h0, ofs}; IBUS_DI = d; IBUS_BA = be;
    IBUS_WE = 1'b1; IBUS_REQ = 1'b1;
    tick();
    IBUS_REQ = 1'b0; IBUS_WE = 1'b0;
  endtask

  task automatic bus_rd(input logic [7:0] ofs, output logic [31:0] d);
    IBUS_A = BASE + {24'h0, ofs}; IBUS_BA = 4'hF;
    IBUS_WE = 1'b0; IBUS_REQ = 1'b1;
    tick();
    IBUS_REQ = 1'b0;
    d = IBUS_DO;
  endtask

  initial begin
    RST_N = 1'b0; CE_R = 1'b1; CE_F = 1'b1; RES_N = 1'b1; NMI_N = 1'b1;
    IRL_N = 4'hF; IBUS_A = '0; IBUS_DI = '0; IBUS_BA = '0; IBUS_WE = 1'b0;
    IBUS_REQ = 1'b0; SRC_IRQ = '0; CPU_MASK = 4'd0; INT_ACK = 1'b0;
    repeat (3) tick();
    RST_N = 1'b1;
    tick();
    check("rst_out", pk(INT_REQ, INT_NMI, INT_LVL, INT_VEC), pk(0, 0, 4'd0, 8'h00));
    check("rst_do", IBUS_DO, 32'h0);
    check("busy", {31'h0, IBUS_BUSY}, 32'h0);

    IBUS_A = BASE + 32'h2C; #1;
    check("act_cfg", {31'h0, IBUS_ACT}, 32'h1);
    IBUS_A = BASE + 32'h40; #1;
    check("act_hole", {31'h0, IBUS_ACT}, 32'h0);
    IBUS_A = 32'hFFFFFE04; #1;
    check("act_other", {31'h0, IBUS_ACT}, 32'h0);

    // Level source 3 against mask 4, then mask 5
    CPU_MASK = 4'd4; SRC_IRQ[3] = 1'b1;
    bus_wr(8'h26, 32'h0000_5040, 4'b0011);
    tick();
    check("lvl_req", pk(INT_REQ, INT_NMI, INT_LVL, INT_VEC), pk(1, 0, 4'd5, 8'h40));
    bus_rd(8'h04, rd);
    check("lvl_pend", rd, 32'h0000_0008);
    CPU_MASK = 4'd5;
    tick();
    check("lvl_masked", pk(INT_REQ, INT_NMI, INT_LVL, INT_VEC), pk(0, 0, 4'd0, 8'h00));
    SRC_IRQ = '0;

    // Edge sources 2 and 6 at equal priority
    bus_wr(8'h24, 32'h7845_0000, 4'b1100);
    bus_wr(8'h2C, 32'h7850_0000, 4'b1100);
    SRC_IRQ = 16'h0044; tick();
    SRC_IRQ = '0;       tick();
    check("tie_low_idx", pk(INT_REQ, INT_NMI, INT_LVL, INT_VEC), pk(1, 0, 4'd7, 8'h45));
    INT_ACK = 1'b1; tick(); INT_ACK = 1'b0;
    check("ack_next", pk(INT_REQ, INT_NMI, INT_LVL, INT_VEC), pk(1, 0, 4'd7, 8'h50));
    bus_rd(8'h04, rd);
    check("ack_pend", rd, 32'h0000_0040);
    INT_ACK = 1'b1; tick(); INT_ACK = 1'b0;
    check("ack_empty", pk(INT_REQ, INT_NMI, INT_LVL, INT_VEC), pk(0, 0, 4'd0, 8'h00));

    // New edge in the same cycle as its ack keeps the pending bit
    SRC_IRQ = 16'h0004; tick();
    SRC_IRQ = '0;       tick();
    check("edge_req", pk(INT_REQ, INT_NMI, INT_LVL, INT_VEC), pk(1, 0, 4'd7, 8'h45));
    INT_ACK = 1'b1; SRC_IRQ = 16'h0004; tick();
    INT_ACK = 1'b0; SRC_IRQ = '0;
    bus_rd(8'h04, rd);
    check("ack_vs_edge", rd, 32'h0000_0004);
    bus_wr(8'h04, 32'h0000_0004, 4'b1111);
    bus_rd(8'h04, rd);
    check("w1c_pend", rd, 32'h0000_0000);
    check("w1c_out", pk(INT_REQ, INT_NMI, INT_LVL, INT_VEC), pk(0, 0, 4'd0, 8'h00));

    // IRL filter: 4 samples rejected, 5 accepted
    IRL_N = 4'b0101; repeat (4) tick();
    IRL_N = 4'hF;    repeat (4) tick();
    check("irl_short", pk(INT_REQ, INT_NMI, INT_LVL, INT_VEC), pk(0, 0, 4'd0, 8'h00));
    IRL_N = 4'b0101; repeat (5) tick();
    check("irl_wait", {31'h0, INT_REQ}, 32'h0);
    tick();
    check("irl_req", pk(INT_REQ, INT_NMI, INT_LVL, INT_VEC), pk(1, 0, 4'd10, 8'h45));

    // Falling NMI preempts IRL; ack returns to IRL
    NMI_N = 1'b0; tick(); tick();
    check("nmi_fall", pk(INT_REQ, INT_NMI, INT_LVL, INT_VEC), pk(1, 1, 4'd15, 8'd11));
    INT_ACK = 1'b1; tick(); INT_ACK = 1'b0;
    check("nmi_to_irl", pk(INT_REQ, INT_NMI, INT_LVL, INT_VEC), pk(1, 0, 4'd10, 8'h45));
    IRL_N = 4'hF; INT_ACK = 1'b1; tick(); INT_ACK = 1'b0;
    tick();
    check("irl_acked", pk(INT_REQ, INT_NMI, INT_LVL, INT_VEC), pk(0, 0, 4'd0, 8'h00));

    // NMIE=1 selects the rising edge
    bus_wr(8'h00, 32'h0100_0000, 4'b1100);
    bus_rd(8'h00, rd);
    check("icr_nmie", rd, 32'h0100_0000);
    NMI_N = 1'b1; tick(); tick();
    check("nmi_rise", pk(INT_REQ, INT_NMI, INT_LVL, INT_VEC), pk(1, 1, 4'd15, 8'd11));
    INT_ACK = 1'b1; tick(); INT_ACK = 1'b0;
    NMI_N = 1'b0; tick(); tick();
    check("nmi_fall_ign", pk(INT_REQ, INT_NMI, INT_LVL, INT_VEC), pk(0, 0, 4'd0, 8'h00));

    // Ack with no request presented is ignored
    CPU_MASK = 4'd15; SRC_IRQ = 16'h0004; tick();
    SRC_IRQ = '0; INT_ACK = 1'b1; tick(); INT_ACK = 1'b0;
    check("mask15_out", pk(INT_REQ, INT_NMI, INT_LVL, INT_VEC), pk(0, 0, 4'd0, 8'h00));
    bus_rd(8'h04, rd);
    check("idle_ack", rd, 32'h0000_0004);
    bus_wr(8'h04, 32'hFFFF_FFFF, 4'b1111);

    // Write masking and byte lanes on CFG0
    bus_wr(8'h20, 32'hA9A3_0000, 4'b1100);
    bus_rd(8'h20, rd);
    check("cfg0_mask", rd, 32'hA823_0000);
    bus_wr(8'h20, 32'h00FF_0000, 4'b0100);
    bus_rd(8'h20, rd);
    check("cfg0_lane", rd, 32'hA87F_0000);
    bus_rd(8'h24, rd);
    check("cfg2_3", rd, 32'h7845_5040);
    bus_rd(8'h40, rd);
    check("hole_rd", rd, 32'h0000_0000);
    bus_rd(8'h2C, rd);
    check("cfg6_7", rd, 32'h7850_0000);

    // Soft reset
    NMI_N = 1'b1; RES_N = 1'b0; tick(); RES_N = 1'b1;
    check("sres_do", IBUS_DO, 32'h0);
    check("sres_out", pk(INT_REQ, INT_NMI, INT_LVL, INT_VEC), pk(0, 0, 4'd0, 8'h00));
    bus_rd(8'h00, rd);
    check("sres_icr", rd, 32'h8000_0000);
    bus_rd(8'h20, rd);
    check("sres_cfg0", rd, 32'h0000_0000);
    bus_rd(8'h24, rd);
    check("sres_cfg2", rd, 32'h0000_0000);
    bus_rd(8'h04, rd);
    check("sres_pend", rd, 32'h0000_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
